// File: rtl/btn_debouncer_if.sv
// ----------------------------------------------------------------------------
// btn_debouncer_if
//   Bundles the button-side and conditioned-output signals of btn_debouncer.
//
//   btn_raw      raw, asynchronous, bouncy button pins (bit i = channel i)
//   btn_level    debounced level per channel
//   btn_press    one-cycle pulse on an accepted 0->1 transition
//   btn_release  one-cycle pulse on an accepted 1->0 transition
//
//   master : the side that owns the pins and consumes the conditioned outputs
//   slave  : the debouncer itself
// ----------------------------------------------------------------------------
interface btn_debouncer_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/btn_debouncer.sv
// ----------------------------------------------------------------------------
// btn_debouncer
//   Conditions raw push-button inputs: per channel a two-flop synchronizer,
//   a four-state debounce FSM and registered single-cycle press/release
//   pulses. Channels are fully independent.
//
//   clk   system clock, all state updates on the rising edge
//   rst   synchronous, active-high reset
//   btn   btn_debouncer_if.slave : btn_raw in, btn_level / btn_press /
//         btn_release out (N_BTN bits each)
//
//   A clean level change on btn_raw shows up on btn_level, together with the
//   matching pulse, DEBOUNCE_CYCLES+2 edges after it is first sampled.
//   DEBOUNCE_CYCLES must be at least 2.
// ----------------------------------------------------------------------------
module btn_debouncer #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic            clk,
  input  logic            rst,
  btn_debouncer_if.slave  btn
);

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } state_e;

  // Last count value before a level change is accepted; the counter never
  // goes past it, so it cannot wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync0_q;
  state_e           state_q [N_BTN];
  state_e           state_d [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];
  logic [CNT_W-1:0] cnt_d   [N_BTN];
  logic [N_BTN-1:0] level_o;
  logic [N_BTN-1:0] press_d;
  logic [N_BTN-1:0] release_d;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] release_q;

  // --------------------------------------------------------------------------
  // State register: synchronizer, FSM state, counters and pulse flops.
  // --------------------------------------------------------------------------
  // NOTE: non-blocking assignments here so every flop samples pre-edge
  // values; this is what makes sync1 -> sync0 a real two-stage chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync0_q   <= '0;
      state_q   <= '{default: IDLE};
      cnt_q     <= '{default: '0};
      press_q   <= '0;
      release_q <= '0;
    end else begin
      sync1_q   <= btn.btn_raw;
      sync0_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and counter logic, one FSM per channel.
  // --------------------------------------------------------------------------
  // NOTE: defaults assigned before the case so no path leaves a variable
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        IDLE: begin
          if (sync0_q[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync0_q[i]) begin
            // Glitch: fall back silently and restart the count.
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!sync0_q[i]) begin
            state_d[i] = RELEASE_WAIT;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i]   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync0_q[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: level decodes the current state; pulses are decoded from the
  // accepting transitions and registered, so they coincide with the first
  // cycle in which btn_level shows the new value.
  // --------------------------------------------------------------------------
  always_comb begin
    level_o   = '0;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      level_o[i]   = (state_q[i] == PRESSED) || (state_q[i] == RELEASE_WAIT);
      press_d[i]   = (state_q[i] == PRESS_WAIT)   && (state_d[i] == PRESSED);
      release_d[i] = (state_q[i] == RELEASE_WAIT) && (state_d[i] == IDLE);
    end
  end

  assign btn.btn_level   = level_o;
  assign btn.btn_press   = press_q;
  assign btn.btn_release = release_q;

endmodule

// File: tb/tb_btn_debouncer.sv
// ----------------------------------------------------------------------------
// tb_btn_debouncer
//   Directed bench for btn_debouncer with N_BTN=2, DEBOUNCE_CYCLES=4.
//   Inputs change and outputs are sampled 1 time unit after each rising edge;
//   a value set after edge k-1 is first sampled at edge k, and a clean change
//   is expected on the outputs right after the 6th edge that samples it.
// ----------------------------------------------------------------------------
module tb_btn_debouncer;

  localparam int N_BTN           = 2;
  localparam int DEBOUNCE_CYCLES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  btn_debouncer_if #(.N_BTN(N_BTN)) bif ();

  btn_debouncer #(
    .N_BTN           (N_BTN),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .btn (bif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] observed,
                       input logic [1:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Advance one edge, then check press / release / level.
  task automatic tick_chk(input string tag, input logic [1:0] exp_press,
                          input logic [1:0] exp_release, input logic [1:0] exp_level);
    @(posedge clk);
    #1;
    check({tag, ".press"},   bif.btn_press,   exp_press);
    check({tag, ".release"}, bif.btn_release, exp_release);
    check({tag, ".level"},   bif.btn_level,   exp_level);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic bounce_seq [10];
    bounce_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // 1. Reset state, then both buttons held through reset release.
    bif.btn_raw = 2'b11;
    rst = 1'b1;
    repeat (3) tick_chk("rst_hold", 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    repeat (5) tick_chk("rst_after", 2'b00, 2'b00, 2'b00);
    tick_chk("rst_press", 2'b11, 2'b00, 2'b11);
    tick_chk("rst_held", 2'b00, 2'b00, 2'b11);
    bif.btn_raw = 2'b00;
    repeat (5) tick_chk("rst_rel_wait", 2'b00, 2'b00, 2'b11);
    tick_chk("rst_rel", 2'b00, 2'b11, 2'b00);
    tick_chk("rst_idle", 2'b00, 2'b00, 2'b00);

    // 2. Clean 20-cycle press on channel 0.
    bif.btn_raw = 2'b01;
    repeat (5) tick_chk("clean_wait", 2'b00, 2'b00, 2'b00);
    tick_chk("clean_press", 2'b01, 2'b00, 2'b01);
    repeat (14) tick_chk("clean_held", 2'b00, 2'b00, 2'b01);
    bif.btn_raw = 2'b00;
    repeat (5) tick_chk("clean_rel_wait", 2'b00, 2'b00, 2'b01);
    tick_chk("clean_rel", 2'b00, 2'b01, 2'b00);
    tick_chk("clean_idle", 2'b00, 2'b00, 2'b00);

    // 3. Bouncy press on channel 0: one press, 6 edges after the last 0->1.
    for (int j = 0; j < 10; j++) begin
      bif.btn_raw = {1'b0, bounce_seq[j]};
      tick_chk("bounce_tog", 2'b00, 2'b00, 2'b00);
    end
    tick_chk("bounce_press", 2'b01, 2'b00, 2'b01);
    repeat (4) tick_chk("bounce_held", 2'b00, 2'b00, 2'b01);
    bif.btn_raw = 2'b00;
    repeat (5) tick_chk("bounce_rel_wait", 2'b00, 2'b00, 2'b01);
    tick_chk("bounce_rel", 2'b00, 2'b01, 2'b00);
    tick_chk("bounce_idle", 2'b00, 2'b00, 2'b00);

    // 4. Three-cycle glitch on channel 1: no effect.
    bif.btn_raw = 2'b10;
    repeat (3) tick_chk("glitch_hi", 2'b00, 2'b00, 2'b00);
    bif.btn_raw = 2'b00;
    repeat (6) tick_chk("glitch_lo", 2'b00, 2'b00, 2'b00);

    // 5. Channel independence: channel 0 pressed two cycles before channel 1.
    bif.btn_raw = 2'b01;
    repeat (2) tick_chk("ind_wait0", 2'b00, 2'b00, 2'b00);
    bif.btn_raw = 2'b11;
    repeat (3) tick_chk("ind_wait1", 2'b00, 2'b00, 2'b00);
    tick_chk("ind_press0", 2'b01, 2'b00, 2'b01);
    tick_chk("ind_gap", 2'b00, 2'b00, 2'b01);
    tick_chk("ind_press1", 2'b10, 2'b00, 2'b11);
    tick_chk("ind_both", 2'b00, 2'b00, 2'b11);
    bif.btn_raw = 2'b01;
    repeat (5) tick_chk("ind_rel1_wait", 2'b00, 2'b00, 2'b11);
    tick_chk("ind_rel1", 2'b00, 2'b10, 2'b01);
    repeat (2) tick_chk("ind_ch0_held", 2'b00, 2'b00, 2'b01);
    bif.btn_raw = 2'b00;
    repeat (5) tick_chk("ind_rel0_wait", 2'b00, 2'b00, 2'b01);
    tick_chk("ind_rel0", 2'b00, 2'b01, 2'b00);
    tick_chk("ind_idle", 2'b00, 2'b00, 2'b00);

    // 6. Reset one cycle before the press would fire, button kept held.
    bif.btn_raw = 2'b01;
    repeat (4) tick_chk("mid_wait", 2'b00, 2'b00, 2'b00);
    rst = 1'b1;
    repeat (2) tick_chk("mid_rst", 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    repeat (5) tick_chk("mid_after", 2'b00, 2'b00, 2'b00);
    tick_chk("mid_press", 2'b01, 2'b00, 2'b01);
    tick_chk("mid_held", 2'b00, 2'b00, 2'b01);

    // Reset while pressed: level drops, no release pulse.
    rst = 1'b1;
    tick_chk("pr_rst", 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    bif.btn_raw = 2'b00;
    repeat (7) tick_chk("pr_after", 2'b00, 2'b00, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
